nvdla_dbb_axi_ram_slave: RTL
============================

Name: nvdla_dbb_axi_ram_slave

Overview:
AXI-style responder for the NVDLA data backbone (DBB) master port. It sits on the far end of the core's M_AXI channels and serves bursts out of an internal byte-enabled RAM. It is used as the on-chip DBB memory in small FPGA configurations and as the bench memory model. Write (AW/W/B) and read (AR/R) paths are independent FSMs sharing one simple-dual-port RAM.

Parameters:
DATA_W, 64, data bus width; fixed 64 in this configuration.
ADDR_W, 32, address width on AW and AR.
ID_W, 8, transaction ID width.
MEM_AW, 12, log2 of RAM depth in DATA_W words (default 4096 x 64b = 32 KiB).

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  synchronous active-low reset
S_AXI_awvalid  in  1  write address valid
S_AXI_awready  out  1  write address ready
S_AXI_awid  in  ID_W  write ID
S_AXI_awlen  in  4  burst length minus 1 (1..16 beats)
S_AXI_awaddr  in  ADDR_W  byte address of first beat
S_AXI_wvalid  in  1  write data valid
S_AXI_wready  out  1  write data ready
S_AXI_wdata  in  DATA_W  write data
S_AXI_wstrb  in  DATA_W/8  byte enables
S_AXI_wlast  in  1  last write beat
S_AXI_bvalid  out  1  write response valid
S_AXI_bready  in  1  write response ready
S_AXI_bid  out  ID_W  write response ID
S_AXI_arvalid  in  1  read address valid
S_AXI_arready  out  1  read address ready
S_AXI_arid  in  ID_W  read ID
S_AXI_arlen  in  4  burst length minus 1
S_AXI_araddr  in  ADDR_W  byte address of first beat
S_AXI_rvalid  out  1  read data valid
S_AXI_rready  in  1  read data ready
S_AXI_rid  out  ID_W  read ID
S_AXI_rlast  out  1  last read beat
S_AXI_rdata  out  DATA_W  read data
wlast_err  out  1  sticky: wlast did not match awlen

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. While asserted: awready, wready, bvalid, arready, rvalid, rlast, wlast_err = 0; bid, rid, rdata = 0; both FSMs go to IDLE. RAM contents are not reset. Reset mid-burst discards the burst; a partial write stays in RAM.
- Addressing: word index = addr[MEM_AW+2:3]. addr[2:0] and bits above the index are ignored. Only INCR bursts. The index increments by 1 per beat and wraps modulo 2^MEM_AW.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch awid, index and len; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata to RAM under wstrb (one write per beat), then increments index and beat count.
  - Exit W_DATA when wlast=1 OR beat count == len. If these disagree, set wlast_err (cleared only by reset). Go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. On bready go to W_IDLE.
  - Handshake rules: bvalid first appears in the cycle after the last W handshake. bid is held stable while bvalid&!bready. awready is 0 outside W_IDLE (one write outstanding).
- Read FSM:
  - R_IDLE: arready=1. On AR handshake at edge t, latch arid and len, and issue the RAM read; go to R_DATA.
  - R_DATA: rvalid rises at t+1 with rdata = mem[index], rid = latched id, rlast = (beat == len).
  - The RAM read address is next-index when (rvalid&rready) else current index. This gives back-to-back beats at full throughput, one beat per cycle while rready=1.
  - rdata, rid and rlast are held stable while rvalid&!rready.
  - On handshake of the rlast beat: rvalid=0 next cycle; return to R_IDLE (arready=1 that cycle).
- Read-during-write to the same word in the same cycle returns the old data.
- AR and AW may complete in the same cycle; the two FSMs never stall each other.
- Latency: AR handshake to first R beat = 1 cycle. Last W beat to bvalid = 1 cycle.

Decomposition:
- Package nvdla_dbb_pkg: DATA_W, ID_W, and LEN_W=4 constants; write FSM state type (W_IDLE, W_DATA, W_RESP); read FSM state type (R_IDLE, R_DATA).
- Sub-module nvdla_dbb_sdp_ram: simple-dual-port, one write port with byte enables, one registered read port, read-old-on-collision. Inferable as BRAM.

Test Plan:
- Single beat: AW addr=0x0000_0040 len=0 id=0x12; W data=0x1122334455667788 strb=0xFF wlast=1 -> bvalid next cycle, bid=0x12. Then AR addr=0x40 len=0 id=0x34 -> rvalid 1 cycle after AR handshake, rdata=0x1122334455667788, rid=0x34, rlast=1.
- 16-beat burst: write beats i=0..15 with data=i at addr 0x100, then read len=15 with rready=1 -> 16 consecutive rvalid cycles, data 0..15, rlast only on beat 15.
- Byte strobes: write all-ones, then write 0 with strb=0x0F -> read returns 0xFFFFFFFF00000000.
- Backpressure and wrap: read len=3 starting at the last RAM word with rready toggling 1,0,0,1... -> data held stable while stalled; beat 1 returns word 0 (wrap). Hold bready=0 for 5 cycles -> bvalid and bid held, awready=0 throughout.
- Errors and reset: AW len=3 with wlast on beat 1 -> B issued after beat 1, wlast_err=1 until reset. Assert reset_n=0 mid read burst -> next edge rvalid=0, arready=0. Release reset -> arready=1 one cycle later, and RAM data is retained.

Source files
------------

// File: rtl/nvdla_dbb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_dbb_pkg
// Purpose  : Shared constants and FSM state types for the DBB RAM responder.
// Revision : 1.0 - initial release
// ============================================================================
package nvdla_dbb_pkg;

  localparam int DATA_W = 64;
  localparam int ID_W   = 8;
  localparam int LEN_W  = 4;

  // Write channel FSM: address accept, data beats, response
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // Read channel FSM: address accept, data beats
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage
`default_nettype wire

// File: rtl/nvdla_dbb_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_dbb_sdp_ram
// Purpose  : Simple-dual-port RAM, byte-enabled write port, registered read
//            port with read enable. A same-address read and write in one
//            cycle returns the old word.
// Revision : 1.0 - initial release
// ============================================================================
module nvdla_dbb_sdp_ram
  import nvdla_dbb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int c_lanes = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_q;

  // Byte-lane write; lanes with a clear strobe keep their old contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < c_lanes; b++) begin
      if (we && wstrb[b]) begin
        r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; holding re low keeps the last word on the output
  always_ff @(posedge clk) begin
    if (re) begin
      r_q <= r_mem[raddr];
    end
  end

  assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/nvdla_dbb_axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_dbb_axi_ram_slave
// Purpose  : AXI-style INCR burst responder for the NVDLA DBB master port,
//            backed by a byte-enabled internal RAM. Independent write
//            (AW/W/B) and read (AR/R) FSMs share one SDP RAM.
// Revision : 1.0 - initial release
// ============================================================================
module nvdla_dbb_axi_ram_slave
  import nvdla_dbb_pkg::*;
#(
  parameter int DATA_W = nvdla_dbb_pkg::DATA_W,
  parameter int ADDR_W = 32,
  parameter int ID_W   = nvdla_dbb_pkg::ID_W,
  parameter int MEM_AW = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 S_AXI_awvalid,
  output logic                 S_AXI_awready,
  input  logic [ID_W-1:0]      S_AXI_awid,
  input  logic [LEN_W-1:0]     S_AXI_awlen,
  input  logic [ADDR_W-1:0]    S_AXI_awaddr,
  input  logic                 S_AXI_wvalid,
  output logic                 S_AXI_wready,
  input  logic [DATA_W-1:0]    S_AXI_wdata,
  input  logic [DATA_W/8-1:0]  S_AXI_wstrb,
  input  logic                 S_AXI_wlast,
  output logic                 S_AXI_bvalid,
  input  logic                 S_AXI_bready,
  output logic [ID_W-1:0]      S_AXI_bid,
  input  logic                 S_AXI_arvalid,
  output logic                 S_AXI_arready,
  input  logic [ID_W-1:0]      S_AXI_arid,
  input  logic [LEN_W-1:0]     S_AXI_arlen,
  input  logic [ADDR_W-1:0]    S_AXI_araddr,
  output logic                 S_AXI_rvalid,
  input  logic                 S_AXI_rready,
  output logic [ID_W-1:0]      S_AXI_rid,
  output logic                 S_AXI_rlast,
  output logic [DATA_W-1:0]    S_AXI_rdata,
  output logic                 wlast_err
);

  // ---------------------------------------------------------------- write path
  w_state_t            r_wstate;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic                r_wlast_err;
  logic [ID_W-1:0]     r_wid;
  logic [MEM_AW-1:0]   r_widx;
  logic [LEN_W-1:0]    r_wlen;
  logic [LEN_W-1:0]    r_wbeat;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_wbeat_at_len;
  logic [MEM_AW-1:0]   w_awidx;

  // Word index: byte offset within the 64-bit word and high bits are dropped
  assign w_awidx        = S_AXI_awaddr[MEM_AW+2:3];
  assign w_aw_hs        = S_AXI_awvalid & r_awready;
  assign w_w_hs         = S_AXI_wvalid & r_wready;
  assign w_wbeat_at_len = (r_wbeat == r_wlen);

  // Write FSM: one burst outstanding; burst ends on wlast or on the awlen count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_wlast_err <= 1'b0;
      r_wid       <= '0;
      r_widx      <= '0;
      r_wlen      <= '0;
      r_wbeat     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_wid     <= S_AXI_awid;
            r_widx    <= w_awidx;
            r_wlen    <= S_AXI_awlen;
            r_wbeat   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx  <= r_widx + 1'b1;
            r_wbeat <= r_wbeat + 1'b1;
            if (S_AXI_wlast || w_wbeat_at_len) begin
              // Either terminator alone ends the burst; disagreement is sticky
              if (S_AXI_wlast != w_wbeat_at_len) begin
                r_wlast_err <= 1'b1;
              end
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_awready = r_awready;
  assign S_AXI_wready  = r_wready;
  assign S_AXI_bvalid  = r_bvalid;
  assign S_AXI_bid     = r_wid;
  assign wlast_err     = r_wlast_err;

  // ----------------------------------------------------------------- read path
  r_state_t            r_rstate;
  logic                r_arready;
  logic                r_rvalid;
  logic                r_rlast;
  logic [ID_W-1:0]     r_rid;
  logic [MEM_AW-1:0]   r_ridx;
  logic [LEN_W-1:0]    r_rlen;
  logic [LEN_W-1:0]    r_rbeat;

  logic                w_ar_hs;
  logic                w_r_hs;
  logic [MEM_AW-1:0]   w_aridx;
  logic                w_ram_re;
  logic [MEM_AW-1:0]   w_ram_raddr;
  logic [DATA_W-1:0]   w_ram_q;

  assign w_aridx = S_AXI_araddr[MEM_AW+2:3];
  assign w_ar_hs = S_AXI_arvalid & r_arready;
  assign w_r_hs  = r_rvalid & S_AXI_rready;

  // RAM read steering: prefetch the next word on a beat handshake so beats
  // stream one per cycle; during a stall the read port is frozen so rdata holds
  always_comb begin
    w_ram_re    = 1'b0;
    w_ram_raddr = r_ridx;
    if (r_rstate == R_IDLE) begin
      w_ram_re    = w_ar_hs;
      w_ram_raddr = w_aridx;
    end else if (w_r_hs) begin
      w_ram_re    = ~r_rlast;
      w_ram_raddr = r_ridx + 1'b1;
    end
  end

  // Read FSM: first beat one cycle after AR, rlast flagged on beat == arlen
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rid     <= S_AXI_arid;
            r_rlen    <= S_AXI_arlen;
            r_ridx    <= w_aridx;
            r_rbeat   <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (S_AXI_arlen == '0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= r_ridx + 1'b1;
              r_rbeat <= r_rbeat + 1'b1;
              r_rlast <= ((r_rbeat + 1'b1) == r_rlen);
            end
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_arready = r_arready;
  assign S_AXI_rvalid  = r_rvalid;
  assign S_AXI_rlast   = r_rlast;
  assign S_AXI_rid     = r_rid;
  // RAM output register is not reset, so gate it to zero when no beat is shown
  assign S_AXI_rdata   = r_rvalid ? w_ram_q : '0;

  // Address bits outside the word index are intentionally ignored
  logic w_unused_addr;
  assign w_unused_addr = ^{S_AXI_awaddr[ADDR_W-1:MEM_AW+3], S_AXI_awaddr[2:0],
                           S_AXI_araddr[ADDR_W-1:MEM_AW+3], S_AXI_araddr[2:0]};

  // ------------------------------------------------------------------ storage
  nvdla_dbb_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_w_hs),
    .waddr (r_widx),
    .wdata (S_AXI_wdata),
    .wstrb (S_AXI_wstrb),
    .re    (w_ram_re),
    .raddr (w_ram_raddr),
    .rdata (w_ram_q)
  );

endmodule
`default_nettype wire
